tnkiii_sprite_line_feeder: RTL and testbench

Per-scanline sprite fetch engine that drives the sprite line buffer's write side. On each line-start strobe it scans sprite attribute RAM, selects sprites that intersect the next scanline, and fetches their 16-pixel row from graphics ROM. For each selected sprite it then issues one write-address load slot (`FL_Y` with `FCK`/`LD`), followed by 16 pixel codes on `FD`, one per `CK0` slot. Pixels whose low three bits are `3'b111` are transparent and are suppressed downstream.

---
 rtl/tnkiii_sprite_line_feeder.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_tnkiii_sprite_line_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnkiii_sprite_line_feeder.sv
// -----------------------------------------------------------------------------
// tnkiii_sprite_line_feeder
//
// Per-scanline sprite fetch engine feeding the write side of the sprite line
// buffer. A line-start strobe (HLD) starts a scan of sprite attribute RAM.
// Each sprite that intersects the prepared line has its 16-pixel row fetched
// from graphics ROM in two 8-pixel halves. The engine then issues one
// line-buffer load slot and 16 pixel slots, all paced by CK0.
//
// Ports
//   clk         system clock, rising edge
//   VIDEO_RSTn  asynchronous active-low reset
//   CK0         pixel-slot enable (one-clk pulse)
//   HLD         line-start pulse (one clk); restarts the engine from any state
//   VLINE[8:0]  line being prepared, sampled on HLD
//   SPR_ADDR    attribute RAM address {index[5:0], byte[1:0]}
//   SPR_DATA    attribute byte, valid one clk after SPR_ADDR
//   ROM_REQ     ROM request, held until ROM_ACK
//   ROM_ADDR    ROM address {tile[7:0], row[3:0], half}
//   ROM_ACK     one-clk acknowledge, ROM_DATA valid in the same cycle
//   ROM_DATA    8 pixels x 3 bits, pixel 0 in [2:0]
//   FD          pixel code {1'b0, color[3:0], pix[2:0]}; 8'h07 is transparent
//   FL_Y        line-buffer start X
//   FCK / LD    line-buffer counter loads when FCK=1 and LD=0
//   BUSY        high from HLD until DONE
//   DONE        one-clk pulse when the line's work is finished
// -----------------------------------------------------------------------------
module tnkiii_sprite_line_feeder #(
    parameter int NUM_SPRITES  = 64,
    parameter int MAX_PER_LINE = 24
) (
    input  logic        clk,
    input  logic        VIDEO_RSTn,
    input  logic        CK0,
    input  logic        HLD,
    input  logic [8:0]  VLINE,
    output logic [7:0]  SPR_ADDR,
    input  logic [7:0]  SPR_DATA,
    output logic        ROM_REQ,
    output logic [12:0] ROM_ADDR,
    input  logic        ROM_ACK,
    input  logic [23:0] ROM_DATA,
    output logic [7:0]  FD,
    output logic [8:0]  FL_Y,
    output logic        FCK,
    output logic        LD,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH0,
        S_FETCH1,
        S_LOADSLOT,
        S_PIX,
        S_FINISH
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_SPRITES - 1);
    localparam logic [6:0] MAX_CNT  = 7'(MAX_PER_LINE);
    localparam logic [7:0] FD_CLEAR = 8'h07;

    // Control and datapath state
    state_t      state_q, state_d;
    logic [8:0]  vline_q, vline_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  step_q, step_d;        // 0..3 address bytes, 4 = evaluate entry
    logic [6:0]  cnt_q, cnt_d;          // sprites rendered on this line
    logic [7:0]  y_q, y_d;
    logic [7:0]  tile_q, tile_d;
    logic [7:0]  attr_q, attr_d;        // {X8, Y8, flipY, flipX, color[3:0]}
    logic [8:0]  x_q, x_d;
    logic [3:0]  row_q, row_d;
    logic [47:0] pix_row_q, pix_row_d;  // half1 in [47:24], half0 in [23:0]
    logic [3:0]  slot_q, slot_d;

    // Registered outputs
    logic [7:0]  spr_addr_q, spr_addr_d;
    logic        rom_req_q, rom_req_d;
    logic [12:0] rom_addr_q, rom_addr_d;
    logic [7:0]  fd_q, fd_d;
    logic [8:0]  fl_y_q, fl_y_d;
    logic        fck_q, fck_d;
    logic        ld_q, ld_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Vertical hit test: distance from the sprite's top edge, modulo 512, so a
    // sprite near Y=511 wraps onto the first lines.
    logic [8:0] dy;
    logic       hit;
    logic [3:0] row_sel;
    logic [3:0] pix_sel;
    logic [2:0] pix_code;

    assign dy       = vline_q - {attr_q[6], y_q};
    assign hit      = (dy[8:4] == 5'd0);
    assign row_sel  = attr_q[5] ? (4'd15 - dy[3:0]) : dy[3:0];
    assign pix_sel  = attr_q[4] ? (4'd15 - slot_q) : slot_q;
    assign pix_code = pix_row_q[6'(pix_sel) * 6'd3 +: 3];

    always_comb begin
        // NOTE: every _d defaults to its _q (or pulse value) first, so no path leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        vline_d    = vline_q;
        idx_d      = idx_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        tile_d     = tile_q;
        attr_d     = attr_q;
        x_d        = x_q;
        row_d      = row_q;
        pix_row_d  = pix_row_q;
        slot_d     = slot_q;
        spr_addr_d = spr_addr_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;
        fd_d       = fd_q;
        fl_y_d     = fl_y_q;
        fck_d      = fck_q;
        ld_d       = ld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (HLD) begin
            // Line start wins over everything, including CK0 and ROM_ACK in
            // the same cycle; an outstanding request is simply abandoned.
            vline_d    = VLINE;
            idx_d      = '0;
            cnt_d      = '0;
            step_d     = '0;
            spr_addr_d = '0;
            rom_req_d  = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_SCAN;
        end else begin
            // Pixel outputs only move on CK0 and hold between slots; outside
            // the load/pixel states a slot drives the transparent code.
            if (CK0 && state_q != S_LOADSLOT && state_q != S_PIX) begin
                fd_d  = FD_CLEAR;
                fck_d = 1'b0;
                ld_d  = 1'b1;
            end

            case (state_q)
                S_IDLE: ;

                S_SCAN: begin
                    // SPR_DATA lags SPR_ADDR by one clk, so step s sees byte s-1.
                    case (step_q)
                        3'd0: begin
                            spr_addr_d = {idx_q, 2'd1};
                            step_d     = 3'd1;
                        end
                        3'd1: begin
                            y_d        = SPR_DATA;
                            spr_addr_d = {idx_q, 2'd2};
                            step_d     = 3'd2;
                        end
                        3'd2: begin
                            tile_d     = SPR_DATA;
                            spr_addr_d = {idx_q, 2'd3};
                            step_d     = 3'd3;
                        end
                        3'd3: begin
                            attr_d = SPR_DATA;
                            step_d = 3'd4;
                        end
                        default: begin
                            if (hit) begin
                                row_d      = row_sel;
                                x_d        = {attr_q[7], SPR_DATA};
                                rom_req_d  = 1'b1;
                                rom_addr_d = {tile_q, row_sel, 1'b0};
                                state_d    = S_FETCH0;
                            end else if (idx_q == LAST_IDX) begin
                                state_d = S_FINISH;
                            end else begin
                                idx_d      = idx_q + 6'd1;
                                step_d     = 3'd0;
                                spr_addr_d = {idx_q + 6'd1, 2'd0};
                            end
                        end
                    endcase
                end

                S_FETCH0: begin
                    if (rom_req_q && ROM_ACK) begin
                        pix_row_d[23:0] = ROM_DATA;
                        rom_req_d       = 1'b0;
                        rom_addr_d      = {tile_q, row_q, 1'b1};
                        state_d         = S_FETCH1;
                    end
                end

                S_FETCH1: begin
                    // Request drops for one clk after the first ACK, then the
                    // second half is requested; ACKs while idle are ignored.
                    if (!rom_req_q) begin
                        rom_req_d = 1'b1;
                    end else if (ROM_ACK) begin
                        pix_row_d[47:24] = ROM_DATA;
                        rom_req_d        = 1'b0;
                        state_d          = S_LOADSLOT;
                    end
                end

                S_LOADSLOT: begin
                    if (CK0) begin
                        fl_y_d  = x_q;
                        fck_d   = 1'b1;
                        ld_d    = 1'b0;
                        slot_d  = 4'd0;
                        state_d = S_PIX;
                    end
                end

                S_PIX: begin
                    if (CK0) begin
                        fd_d   = {1'b0, attr_q[3:0], pix_code};
                        fck_d  = 1'b0;
                        ld_d   = 1'b1;
                        slot_d = slot_q + 4'd1;
                        if (slot_q == 4'd15) begin
                            cnt_d = cnt_q + 7'd1;
                            if ((cnt_q + 7'd1 == MAX_CNT) || (idx_q == LAST_IDX)) begin
                                state_d = S_FINISH;
                            end else begin
                                idx_d      = idx_q + 6'd1;
                                step_d     = 3'd0;
                                spr_addr_d = {idx_q + 6'd1, 2'd0};
                                state_d    = S_SCAN;
                            end
                        end
                    end
                end

                S_FINISH: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            state_q    <= S_IDLE;
            vline_q    <= '0;
            idx_q      <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            y_q        <= '0;
            tile_q     <= '0;
            attr_q     <= '0;
            x_q        <= '0;
            row_q      <= '0;
            // NOTE: the pixel row is plain datapath, not a memory array; resetting it keeps the outputs X-free at no real cost.
            pix_row_q  <= '0;
            slot_q     <= '0;
            spr_addr_q <= '0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            fd_q       <= FD_CLEAR;
            fl_y_q     <= '0;
            fck_q      <= 1'b0;
            ld_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            vline_q    <= vline_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            tile_q     <= tile_d;
            attr_q     <= attr_d;
            x_q        <= x_d;
            row_q      <= row_d;
            pix_row_q  <= pix_row_d;
            slot_q     <= slot_d;
            spr_addr_q <= spr_addr_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            fd_q       <= fd_d;
            fl_y_q     <= fl_y_d;
            fck_q      <= fck_d;
            ld_q       <= ld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SPR_ADDR = spr_addr_q;
    assign ROM_REQ  = rom_req_q;
    assign ROM_ADDR = rom_addr_q;
    assign FD       = fd_q;
    assign FL_Y     = fl_y_q;
    assign FCK      = fck_q;
    assign LD       = ld_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_tnkiii_sprite_line_feeder.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for tnkiii_sprite_line_feeder.
// Models a synchronous attribute RAM, a ROM with fixed latency, a CK0 pulse
// every 4 clks, and logs every CK0 slot's outputs for later comparison.
// -----------------------------------------------------------------------------
module tb_tnkiii_sprite_line_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ck0 = 1'b0;
    logic        hld = 1'b0;
    logic [8:0]  vline = '0;
    logic [7:0]  spr_addr;
    logic [7:0]  spr_data = '0;
    logic        rom_req;
    logic [12:0] rom_addr;
    logic        rom_ack;
    logic [23:0] rom_data;
    logic [7:0]  fd;
    logic [8:0]  fl_y;
    logic        fck;
    logic        ld;
    logic        busy;
    logic        done;

    logic        ack_auto = 1'b0;
    logic        ack_man  = 1'b0;
    logic        rom_auto = 1'b1;
    int          rom_wait = 0;
    int          ck0_div  = 0;
    int          done_cnt = 0;

    int          total = 0;
    int          bad   = 0;

    logic [7:0]  attr_mem [0:255];
    logic [12:0] rom_log [$];

    typedef struct packed {
        logic       fck;
        logic       ld;
        logic [8:0] fl_y;
        logic [7:0] fd;
    } slot_t;
    slot_t slot_log [$];

    always #5 clk = ~clk;

    tnkiii_sprite_line_feeder #(
        .NUM_SPRITES (64),
        .MAX_PER_LINE(24)
    ) dut (
        .clk       (clk),
        .VIDEO_RSTn(rst_n),
        .CK0       (ck0),
        .HLD       (hld),
        .VLINE     (vline),
        .SPR_ADDR  (spr_addr),
        .SPR_DATA  (spr_data),
        .ROM_REQ   (rom_req),
        .ROM_ADDR  (rom_addr),
        .ROM_ACK   (rom_ack),
        .ROM_DATA  (rom_data),
        .FD        (fd),
        .FL_Y      (fl_y),
        .FCK       (fck),
        .LD        (ld),
        .BUSY      (busy),
        .DONE      (done)
    );

    // ROM content: pixel i of word at address a is (5a + 3i) mod 8.
    function automatic logic [23:0] rom_word(input logic [12:0] a);
        logic [23:0] w;
        int          v;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            v = int'(a) * 5 + i * 3;
            w[3*i +: 3] = 3'(v);
        end
        return w;
    endfunction

    function automatic logic [7:0] exp_fd(input logic [7:0] tile, input logic [3:0] row,
                                          input logic [3:0] color, input logic flipx,
                                          input int k);
        int          p;
        logic [23:0] w;
        p = flipx ? 15 - k : k;
        w = rom_word({tile, row, (p >= 8)});
        return {1'b0, color, w[3*(p%8) +: 3]};
    endfunction

    assign rom_data = rom_word(rom_addr);
    assign rom_ack  = ack_auto | ack_man;

    // Synchronous attribute RAM: data follows the address by one clk.
    always @(posedge clk) spr_data <= attr_mem[spr_addr];

    // ROM responder: acknowledges a held request on the third negedge.
    always @(negedge clk) begin
        ack_auto = 1'b0;
        if (rom_auto && rom_req) begin
            if (rom_wait >= 2) begin
                ack_auto = 1'b1;
                rom_wait = 0;
                rom_log.push_back(rom_addr);
            end else begin
                rom_wait++;
            end
        end else begin
            rom_wait = 0;
        end
    end

    // CK0 generator and slot / DONE logger. At the negedge, ck0 still holds
    // the value the DUT sampled at the preceding posedge.
    always @(negedge clk) begin
        if (ck0) slot_log.push_back({fck, ld, fl_y, fd});
        if (done) done_cnt++;
        ck0_div = (ck0_div + 1) % 4;
        ck0     = (ck0_div == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic [8:0] y, input logic [7:0] tile,
                             input logic [3:0] color, input logic flipy, input logic flipx,
                             input logic [8:0] x);
        attr_mem[i*4 + 0] = y[7:0];
        attr_mem[i*4 + 1] = tile;
        attr_mem[i*4 + 2] = {x[8], y[8], flipy, flipx, color};
        attr_mem[i*4 + 3] = x[7:0];
    endtask

    // Y=200 misses every line used below.
    task automatic clear_attr();
        for (int i = 0; i < 64; i++) set_entry(i, 9'd200, 8'd0, 4'd0, 1'b0, 1'b0, 9'd0);
    endtask

    // Called at a negedge; returns at the negedge just after HLD was sampled.
    task automatic start_line(input logic [8:0] v);
        vline = v;
        hld   = 1'b1;
        @(negedge clk);
        hld   = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_clear", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    function automatic int count_loads(input int base);
        int n;
        n = 0;
        for (int i = base; i < slot_log.size(); i++)
            if (slot_log[i].fck && !slot_log[i].ld) n++;
        return n;
    endfunction

    task automatic check_sprite(input string tag, input int base, input int nth,
                                input logic [8:0] x, input logic [7:0] tile,
                                input logic [3:0] row, input logic [3:0] color,
                                input logic flipx);
        int li;
        int seen;
        li   = -1;
        seen = 0;
        for (int i = base; i < slot_log.size(); i++) begin
            if (li < 0 && slot_log[i].fck && !slot_log[i].ld) begin
                if (seen == nth) li = i;
                seen++;
            end
        end
        check({tag, "_load"}, 32'(li >= 0), 32'd1);
        if (li >= 0) begin
            check({tag, "_fl_y"}, 32'(slot_log[li].fl_y), 32'(x));
            check({tag, "_slots"}, 32'(slot_log.size() >= li + 17), 32'd1);
            for (int k = 0; k < 16; k++) begin
                if (li + 1 + k < slot_log.size())
                    check($sformatf("%s_pix%0d", tag, k), 32'(slot_log[li+1+k].fd),
                          32'(exp_fd(tile, row, color, flipx, k)));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int sbase;
        int rbase;
        int dbase;

        clear_attr();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_spr_addr", 32'(spr_addr), 32'h00);
        check("rst_rom_req",  32'(rom_req),  32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_fd",       32'(fd),       32'h07);
        check("rst_fl_y",     32'(fl_y),     32'd0);
        check("rst_fck",      32'(fck),      32'd0);
        check("rst_ld",       32'(ld),       32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single sprite: Y=10, tile 3, color 5, X=20, line 12 -> row 2
        set_entry(0, 9'd10, 8'd3, 4'd5, 1'b0, 1'b0, 9'd20);
        sbase = slot_log.size(); rbase = rom_log.size(); dbase = done_cnt;
        start_line(9'd12);
        check("single_addr0", 32'(spr_addr), 32'h00);
        check("single_busy",  32'(busy),     32'd1);
        @(negedge clk);
        check("single_addr1", 32'(spr_addr), 32'h01);
        wait_done(cyc);
        check("single_rom_cnt", 32'(rom_log.size() - rbase), 32'd2);
        if (rom_log.size() - rbase >= 2) begin
            check("single_rom0", 32'(rom_log[rbase]),     32'd100);
            check("single_rom1", 32'(rom_log[rbase + 1]), 32'd101);
        end
        check("single_loads", 32'(count_loads(sbase)), 32'd1);
        check_sprite("single", sbase, 0, 9'd20, 8'd3, 4'd2, 4'd5, 1'b0);
        check("single_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // Flips: row 15-2=13, pixels emitted 15..0
        set_entry(0, 9'd10, 8'd3, 4'd5, 1'b1, 1'b1, 9'd20);
        sbase = slot_log.size(); rbase = rom_log.size();
        start_line(9'd12);
        wait_done(cyc);
        check("flip_rom_cnt", 32'(rom_log.size() - rbase), 32'd2);
        if (rom_log.size() - rbase >= 2) begin
            check("flip_rom0", 32'(rom_log[rbase]),     32'd122);
            check("flip_rom1", 32'(rom_log[rbase + 1]), 32'd123);
        end
        check_sprite("flip", sbase, 0, 9'd20, 8'd3, 4'd13, 4'd5, 1'b1);

        // Y wrap: Y=0x1F8, line 2 -> dy=10; X=510 exercises X8
        set_entry(0, 9'h1F8, 8'd7, 4'd2, 1'b0, 1'b0, 9'd510);
        sbase = slot_log.size(); rbase = rom_log.size();
        start_line(9'd2);
        wait_done(cyc);
        check("ywrap_rom_cnt", 32'(rom_log.size() - rbase), 32'd2);
        if (rom_log.size() - rbase >= 2) begin
            check("ywrap_rom0", 32'(rom_log[rbase]),     32'd244);
            check("ywrap_rom1", 32'(rom_log[rbase + 1]), 32'd245);
        end
        check_sprite("ywrap", sbase, 0, 9'd510, 8'd7, 4'd10, 4'd2, 1'b0);

        // All miss: line 30 vs Y=10; DONE after 64 entries x 5 clk + FINISH
        set_entry(0, 9'd10, 8'd3, 4'd5, 1'b0, 1'b0, 9'd20);
        sbase = slot_log.size(); rbase = rom_log.size();
        start_line(9'd30);
        wait_done(cyc);
        check("miss_cycles",  32'(cyc), 32'd321);
        check("miss_rom_cnt", 32'(rom_log.size() - rbase), 32'd0);
        check("miss_loads",   32'(count_loads(sbase)), 32'd0);

        // Sprite budget: 30 hits, only 24 rendered
        clear_attr();
        for (int i = 0; i < 30; i++) set_entry(i, 9'd10, 8'(i), 4'd1, 1'b0, 1'b0, 9'(i * 8));
        sbase = slot_log.size(); rbase = rom_log.size();
        start_line(9'd12);
        wait_done(cyc);
        check("budget_loads",   32'(count_loads(sbase)), 32'd24);
        check("budget_rom_cnt", 32'(rom_log.size() - rbase), 32'd48);
        if (rom_log.size() - rbase >= 47)
            check("budget_rom_last", 32'(rom_log[rbase + 46]), 32'd740);
        check_sprite("budget23", sbase, 23, 9'd184, 8'd23, 4'd2, 4'd1, 1'b0);

        // Abort while FETCH1 waits on ACK
        clear_attr();
        set_entry(0, 9'd10, 8'd3, 4'd5, 1'b0, 1'b0, 9'd20);
        rom_auto = 1'b0;
        start_line(9'd12);
        cyc = 0;
        while (!rom_req && cyc < 200) begin @(negedge clk); cyc++; end
        check("abort_req0",  32'(rom_req),  32'd1);
        check("abort_addr0", 32'(rom_addr), 32'd100);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        cyc = 0;
        while (!rom_req && cyc < 200) begin @(negedge clk); cyc++; end
        check("abort_addr1", 32'(rom_addr), 32'd101);
        repeat (3) @(negedge clk);
        check("abort_req_held", 32'(rom_req), 32'd1);
        sbase = slot_log.size(); rbase = rom_log.size(); dbase = done_cnt;
        start_line(9'd12);
        check("abort_req_drop", 32'(rom_req),  32'd0);
        check("abort_rescan",   32'(spr_addr), 32'h00);
        check("abort_busy",     32'(busy),     32'd1);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        check("abort_late_ack", 32'(rom_req), 32'd0);
        rom_auto = 1'b1;
        wait_done(cyc);
        check("abort_done_cnt", 32'(done_cnt - dbase), 32'd1);
        check("abort_rom_cnt",  32'(rom_log.size() - rbase), 32'd2);
        if (rom_log.size() - rbase >= 1)
            check("abort_rom0", 32'(rom_log[rbase]), 32'd100);
        check_sprite("abort", sbase, 0, 9'd20, 8'd3, 4'd2, 4'd5, 1'b0);

        // Asynchronous reset in the middle of the pixel slots
        start_line(9'd12);
        cyc = 0;
        while (!fck && cyc < 500) begin @(negedge clk); cyc++; end
        check("rstmid_load", 32'(fck), 32'd1);
        repeat (12) @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        check("rstmid_fl_y_before", 32'(fl_y), 32'd20);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_spr_addr", 32'(spr_addr), 32'h00);
        check("rstmid_rom_req",  32'(rom_req),  32'd0);
        check("rstmid_rom_addr", 32'(rom_addr), 32'd0);
        check("rstmid_fd",       32'(fd),       32'h07);
        check("rstmid_fl_y",     32'(fl_y),     32'd0);
        check("rstmid_fck",      32'(fck),      32'd0);
        check("rstmid_ld",       32'(ld),       32'd1);
        check("rstmid_busy",     32'(busy),     32'd0);
        check("rstmid_done",     32'(done),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
